// File: rtl/seq_det_ctrl.sv
// Serial pattern detector with run/done control and a configurable pattern, length, overlap mode and match target.
// Optional accepted-bit timeout is compiled in with SEQ_CTRL_TIMEOUT_EN.
module seq_det_ctrl #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_valid,
  input  logic [7:0] cfg_pattern,
  input  logic [2:0] cfg_len,
  input  logic       cfg_overlap,
  input  logic [3:0] cfg_target,
  input  logic       start,
  input  logic       stop,
  input  logic       seq_in,
  input  logic       seq_valid,
  output logic       cfg_ready,
  output logic       detected,
  output logic [3:0] match_count,
  output logic       done,
  output logic       timeout,
  output logic [1:0] state_out
);

  // state   | meaning
  // IDLE    | waiting for start, configuration writable
  // RUN     | shifting accepted bits and counting matches
  // DONE    | match target reached, configuration writable
  // TIMEOUT | too many bits without a match
  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RUN     = 2'b01,
    S_DONE    = 2'b10,
    S_TIMEOUT = 2'b11
  } state_t;

  state_t     state;

  // Stored configuration is writable from IDLE/DONE; the active copy is
  // taken at start so a write in DONE cannot disturb the finished run.
  logic [7:0] pat_q;
  logic [2:0] len_q;
  logic       ovl_q;
  logic [3:0] tgt_q;
  logic [7:0] act_pat;
  logic [2:0] act_len;
  logic       act_ovl;
  logic [3:0] act_tgt;

  logic [7:0] history;
  logic [3:0] fill;
  logic [3:0] count_q;
  logic       detected_q;

  logic [7:0] hist_next;
  logic [3:0] fill_inc;
  logic [7:0] len_mask;
  logic [3:0] eff_target;
  logic [3:0] count_inc;
  logic       hit;

  always_comb begin
    hist_next  = {history[6:0], seq_in};
    fill_inc   = (fill == 4'd8) ? 4'd8 : fill + 4'd1;
    len_mask   = 8'h00;
    for (int i = 0; i < 8; i++) begin
      len_mask[i] = (i <= int'(act_len));
    end
    eff_target = (act_tgt == 4'd0) ? 4'd1 : act_tgt;
    count_inc  = count_q + 4'd1;
    hit        = (fill_inc >= ({1'b0, act_len} + 4'd1)) &&
                 (((hist_next ^ act_pat) & len_mask) == 8'h00);
  end

`ifdef SEQ_CTRL_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
  logic [7:0] tcnt;
  logic [7:0] tcnt_inc;

  always_comb tcnt_inc = tcnt + 8'd1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pat_q      <= 8'h00;
      len_q      <= 3'd0;
      ovl_q      <= 1'b0;
      tgt_q      <= 4'd0;
      act_pat    <= 8'h00;
      act_len    <= 3'd0;
      act_ovl    <= 1'b0;
      act_tgt    <= 4'd0;
      history    <= 8'h00;
      fill       <= 4'd0;
      count_q    <= 4'd0;
      detected_q <= 1'b0;
`ifdef SEQ_CTRL_TIMEOUT_EN
      tcnt       <= 8'd0;
`endif
    end else begin
      detected_q <= 1'b0;
      if (cfg_valid && cfg_ready) begin
        pat_q <= cfg_pattern;
        len_q <= cfg_len;
        ovl_q <= cfg_overlap;
        tgt_q <= cfg_target;
      end
      if (stop) begin
        state <= S_IDLE;
      end else if (start && (state != S_RUN)) begin
        state   <= S_RUN;
        act_pat <= pat_q;
        act_len <= len_q;
        act_ovl <= ovl_q;
        act_tgt <= tgt_q;
        history <= 8'h00;
        fill    <= 4'd0;
        count_q <= 4'd0;
`ifdef SEQ_CTRL_TIMEOUT_EN
        tcnt    <= 8'd0;
`endif
      end else if ((state == S_RUN) && seq_valid) begin
        history <= hist_next;
        if (hit) begin
          detected_q <= 1'b1;
          count_q    <= count_inc;
          fill       <= act_ovl ? fill_inc : 4'd0;
`ifdef SEQ_CTRL_TIMEOUT_EN
          tcnt       <= 8'd0;
`endif
          if (count_inc >= eff_target) begin
            state <= S_DONE;
          end
        end else begin
          fill <= fill_inc;
`ifdef SEQ_CTRL_TIMEOUT_EN
          tcnt <= tcnt_inc;
          if (tcnt_inc == TIMEOUT_CNT) begin
            state <= S_TIMEOUT;
          end
`endif
        end
      end
    end
  end

  assign cfg_ready   = (state == S_IDLE) || (state == S_DONE);
  assign detected    = detected_q;
  assign match_count = count_q;
  assign done        = (state == S_DONE);
  assign state_out   = state;
`ifdef SEQ_CTRL_TIMEOUT_EN
  assign timeout     = (state == S_TIMEOUT);
`else
  assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Scoreboard bench for seq_det_ctrl: directed bit streams push expected detections,
// a negedge monitor pops and compares them whenever detected pulses.
module tb_seq_det_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_pattern = 8'h00;
  logic [2:0] cfg_len = 3'd0;
  logic       cfg_overlap = 1'b0;
  logic [3:0] cfg_target = 4'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       seq_in = 1'b0;
  logic       seq_valid = 1'b0;
  logic       cfg_ready;
  logic       detected;
  logic [3:0] match_count;
  logic       done;
  logic       timeout;
  logic [1:0] state_out;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] cnt;
    logic       dn;
  } exp_t;
  exp_t exp_q[$];

  seq_det_ctrl #(.TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
    .start(start), .stop(stop), .seq_in(seq_in), .seq_valid(seq_valid),
    .cfg_ready(cfg_ready), .detected(detected), .match_count(match_count),
    .done(done), .timeout(timeout), .state_out(state_out)
  );

  always #5 clk = ~clk;

  // Monitor: every detected pulse must correspond to a queued expectation.
  always @(negedge clk) begin
    if (detected) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_detect match_count=%0d done=%0d", match_count, done);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (match_count !== e.cnt || done !== e.dn ||
            state_out !== (e.dn ? 2'b10 : 2'b01)) begin
          failures++;
          $display("FAIL detect_sb got cnt=%0d done=%0d state=%0d expected cnt=%0d done=%0d state=%0d",
                   match_count, done, state_out, e.cnt, e.dn, e.dn ? 2 : 1);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, act, expv);
    end
  endtask

  task automatic drained(input string name);
    step();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s missing_detects got=0 expected=%0d", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic cfg(input logic [7:0] pat, input logic [2:0] len,
                     input logic ov, input logic [3:0] tgt);
    cfg_pattern = pat; cfg_len = len; cfg_overlap = ov; cfg_target = tgt;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic send(input logic b, input logic det, input logic [3:0] cnt, input logic dn);
    seq_in = b;
    seq_valid = 1'b1;
    if (det) exp_q.push_back('{cnt: cnt, dn: dn});
    step();
    seq_valid = 1'b0;
  endtask

  task automatic gap(input logic b);
    seq_in = b;
    seq_valid = 1'b0;
    step();
  endtask

  initial begin
    // Reset values
    step(); step();
    chk("rst_state", {6'd0, state_out}, 8'd0);
    chk("rst_cfg_ready", {7'd0, cfg_ready}, 8'd1);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_timeout", {7'd0, timeout}, 8'd0);
    chk("rst_count", {4'd0, match_count}, 8'd0);
    rst_n = 1'b1;
    step();

    // Pattern 1010, non-overlap: one match after bit 4
    cfg(8'h0A, 3'd3, 1'b0, 4'd15);
    do_start();
    chk("run_state", {6'd0, state_out}, 8'd1);
    chk("run_cfg_ready", {7'd0, cfg_ready}, 8'd0);
    send(1, 0, 0, 0); send(0, 0, 0, 0); send(1, 0, 0, 0); send(0, 1, 1, 0);
    send(1, 0, 0, 0); send(0, 0, 0, 0);
    drained("nonoverlap");
    chk("nonoverlap_count", {4'd0, match_count}, 8'd1);

    // Same stream, overlap: matches after bits 4 and 6
    do_stop();
    chk("stop_state", {6'd0, state_out}, 8'd0);
    chk("stop_hold_count", {4'd0, match_count}, 8'd1);
    cfg(8'h0A, 3'd3, 1'b1, 4'd15);
    do_start();
    chk("start_clear_count", {4'd0, match_count}, 8'd0);
    send(1, 0, 0, 0); send(0, 0, 0, 0); send(1, 0, 0, 0); send(0, 1, 1, 0);
    send(1, 0, 0, 0); send(0, 1, 2, 0);
    drained("overlap");
    chk("overlap_count", {4'd0, match_count}, 8'd2);

    // Target 2, non-overlap: done with second match, later bits ignored
    do_stop();
    cfg(8'h0A, 3'd3, 1'b0, 4'd2);
    do_start();
    send(1, 0, 0, 0); send(0, 0, 0, 0); send(1, 0, 0, 0); send(0, 1, 1, 0);
    send(1, 0, 0, 0); send(0, 0, 0, 0); send(1, 0, 0, 0); send(0, 1, 2, 1);
    drained("target2");
    chk("done_state", {6'd0, state_out}, 8'd2);
    chk("done_level", {7'd0, done}, 8'd1);
    chk("done_cfg_ready", {7'd0, cfg_ready}, 8'd1);

    // New config in DONE only applies at next start; bits in DONE ignored
    cfg(8'h05, 3'd3, 1'b0, 4'd15);
    send(1, 0, 0, 0); send(0, 0, 0, 0); send(1, 0, 0, 0); send(0, 0, 0, 0);
    drained("done_ignore");
    chk("done_hold_count", {4'd0, match_count}, 8'd2);
    chk("done_hold_state", {6'd0, state_out}, 8'd2);
    do_start();
    send(1, 0, 0, 0); send(0, 0, 0, 0); send(1, 0, 0, 0); send(0, 0, 0, 0);
    send(1, 1, 1, 0);
    drained("new_pattern");

    // cfg write in RUN ignored; start+stop together goes IDLE
    cfg(8'hFF, 3'd3, 1'b0, 4'd15);
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("stop_wins_state", {6'd0, state_out}, 8'd0);
    chk("stop_wins_count", {4'd0, match_count}, 8'd1);
    do_start();
    chk("restart_count", {4'd0, match_count}, 8'd0);
    send(0, 0, 0, 0); send(1, 0, 0, 0); send(0, 0, 0, 0); send(1, 1, 1, 0);
    drained("cfg_in_run_ignored");

    // Reset mid-run with inputs active: all outputs to reset values
    send(1, 0, 0, 0); send(0, 0, 0, 0);
    rst_n = 1'b0;
    cfg_pattern = 8'hFF; cfg_len = 3'd7; cfg_target = 4'd9; cfg_valid = 1'b1; start = 1'b1;
    step();
    rst_n = 1'b1; cfg_valid = 1'b0; start = 1'b0;
    chk("midrst_state", {6'd0, state_out}, 8'd0);
    chk("midrst_count", {4'd0, match_count}, 8'd0);
    chk("midrst_detected", {7'd0, detected}, 8'd0);
    chk("midrst_done", {7'd0, done}, 8'd0);
    chk("midrst_cfg_ready", {7'd0, cfg_ready}, 8'd1);
    // Cleared config: 1-bit pattern 0, target 0 treated as 1
    do_start();
    send(0, 1, 1, 1);
    drained("reset_cfg_target0");
    chk("target0_state", {6'd0, state_out}, 8'd2);

    // seq_valid gaps between bits do not affect matching
    cfg(8'h0A, 3'd3, 1'b0, 4'd15);
    do_start();
    send(1, 0, 0, 0); gap(0); gap(1);
    send(0, 0, 0, 0); gap(1);
    send(1, 0, 0, 0); gap(1); gap(0);
    send(0, 1, 1, 0);
    drained("gaps");
    chk("gaps_count", {4'd0, match_count}, 8'd1);

    // 64 zeros against 1010
    do_stop();
    do_start();
    for (int i = 0; i < 63; i++) send(0, 0, 0, 0);
    chk("pre_timeout_state", {6'd0, state_out}, 8'd1);
    send(0, 0, 0, 0);
`ifdef SEQ_CTRL_TIMEOUT_EN
    chk("timeout_state", {6'd0, state_out}, 8'd3);
    chk("timeout_level", {7'd0, timeout}, 8'd1);
    chk("timeout_cfg_ready", {7'd0, cfg_ready}, 8'd0);
    do_start();
    chk("rearm_state", {6'd0, state_out}, 8'd1);
    chk("rearm_timeout", {7'd0, timeout}, 8'd0);
`else
    chk("no_timeout_state", {6'd0, state_out}, 8'd1);
    chk("no_timeout_level", {7'd0, timeout}, 8'd0);
`endif
    drained("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
